// File: rtl/mips_route_pkg.sv
// Shared lane-select encoding for the result routing fabric.
// Matches the encoding used by the 4:1 datapath select muxes.
package mips_route_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  localparam lane_sel_t LANE_ZERO  = 2'b00;
  localparam lane_sel_t LANE_ONE   = 2'b01;
  localparam lane_sel_t LANE_TWO   = 2'b10;
  localparam lane_sel_t LANE_THREE = 2'b11;

  function automatic logic [NUM_LANES-1:0] lane_onehot(
    input lane_sel_t sel
  );
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    unique case (sel)
      LANE_ZERO:  oh = 4'b0001;
      LANE_ONE:   oh = 4'b0010;
      LANE_TWO:   oh = 4'b0100;
      LANE_THREE: oh = 4'b1000;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer for a single demux lane,
// with its valid bit and wrapping delivery counter.
module demux_lane
  import mips_route_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              drain_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              can_accept
);

  logic drain;

  assign drain      = valid & drain_ready;
  assign can_accept = ~valid | drain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Wraps silently at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (drain) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_to_4_buf.sv
// Registered 1-to-4 demux: routes one producer word to one of
// four single-entry consumer lanes with valid/ready on each side.
module demux_1_to_4_buf
  import mips_route_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  lane_sel_t                         in_select,
  output logic [NUM_LANES-1:0]              out_valid,
  input  logic [NUM_LANES-1:0]              out_ready,
  output logic [NUM_LANES-1:0][DATA_W-1:0]  out_data,
  output logic [NUM_LANES-1:0][CNT_W-1:0]   out_count,
  output logic                              busy
);

  logic [NUM_LANES-1:0] can_accept;
  logic [NUM_LANES-1:0] fill;
  logic                 in_fire;

  // Ready looks only at the selected lane so a stall elsewhere never blocks.
  assign in_ready = can_accept[in_select];
  assign in_fire  = in_valid & in_ready;
  assign fill     = in_fire ? lane_onehot(in_select) : '0;
  assign busy     = |out_valid;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill        (fill[i]),
      .fill_data   (in_data),
      .drain_ready (out_ready[i]),
      .valid       (out_valid[i]),
      .data        (out_data[i]),
      .count       (out_count[i]),
      .can_accept  (can_accept[i])
    );
  end

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Bench for demux_1_to_4_buf: per-lane scoreboard queues and a
// lane-state model checked every cycle, plus directed scenarios.
module tb_demux_1_to_4_buf;
  import mips_route_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  lane_sel_t                   in_select;
  logic [3:0]                  out_valid;
  logic [3:0]                  out_ready;
  logic [3:0][DATA_W-1:0]      out_data;
  logic [3:0][CNT_W-1:0]       out_count;
  logic                        busy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q [4][$];
  logic [3:0]        mvalid;
  logic [CNT_W-1:0]  mcount [4];

  demux_1_to_4_buf #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_select (in_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane model: inputs are stable at negedge, so predict the next edge here.
  always @(negedge clk or negedge rst_n) begin
    logic [3:0] nv;
    logic mready;
    logic [DATA_W-1:0] exp;
    if (!rst_n) begin
      mvalid = '0;
      for (int i = 0; i < 4; i++) begin
        mcount[i] = '0;
        q[i].delete();
      end
    end else begin
      checks++;
      if (out_valid !== mvalid) begin
        errors++;
        $display("FAIL mon_valid: got %b want %b", out_valid, mvalid);
      end
      checks++;
      if (busy !== (|mvalid)) begin
        errors++;
        $display("FAIL mon_busy: got %b want %b", busy, |mvalid);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_count[i] !== mcount[i]) begin
          errors++;
          $display("FAIL mon_count%0d: got %0d want %0d",
                   i, out_count[i], mcount[i]);
        end
      end
      mready = !mvalid[in_select] || out_ready[in_select];
      checks++;
      if (in_ready !== mready) begin
        errors++;
        $display("FAIL mon_in_ready: got %b want %b", in_ready, mready);
      end
      nv = mvalid;
      for (int i = 0; i < 4; i++) begin
        if (mvalid[i] && out_ready[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL mon_underflow%0d: got delivery want none", i);
          end else begin
            exp = q[i].pop_front();
            if (out_data[i] !== exp) begin
              errors++;
              $display("FAIL mon_data%0d: got %h want %h",
                       i, out_data[i], exp);
            end
          end
          mcount[i] = mcount[i] + 1'b1;
          nv[i] = 1'b0;
        end
      end
      if (in_valid && mready) begin
        q[in_select].push_back(in_data);
        nv[in_select] = 1'b1;
      end
      mvalid = nv;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input lane_sel_t s,
                       input logic [DATA_W-1:0] d);
    in_valid  = v;
    in_select = s;
    in_data   = d;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 ||
        out_data !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_init: got v=%b busy=%b want 0", out_valid, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b0000;
    drive(1'b1, LANE_TWO, 32'hAAAA_5555);
    cycle();
    drive(1'b0, LANE_ZERO, '0);
    checks++;
    if (out_valid !== 4'b0100) begin
      errors++;
      $display("FAIL reset_prefill: got %b want 0100", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 ||
        out_data !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b busy=%b d2=%h want 0",
               out_valid, busy, out_data[2]);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 4'b1111;
    drive(1'b1, LANE_TWO, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, LANE_ZERO, '0);
    checks++;
    if (out_valid !== 4'b0100 || out_data[2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_route: got v=%b d=%h want 0100 deadbeef",
               out_valid, out_data[2]);
    end
    cycle();
    checks++;
    if (out_valid !== 4'b0000 || out_count[2] !== 8'd1) begin
      errors++;
      $display("FAIL basic_drain: got v=%b c=%0d want 0000 1",
               out_valid, out_count[2]);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    drive(1'b1, LANE_ONE, 32'h1111_1111);
    cycle();
    drive(1'b1, LANE_ONE, 32'h2222_2222);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: got %b want 0", in_ready);
    end
    cycle();
    checks++;
    if (out_data[1] !== 32'h1111_1111 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got d=%h r=%b want 11111111 0",
               out_data[1], in_ready);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_high: got %b want 1", in_ready);
    end
    cycle();
    drive(1'b0, LANE_ZERO, '0);
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL bp_refill: got v=%b d=%h want 1 22222222",
               out_valid[1], out_data[1]);
    end
    cycle();
    checks++;
    if (out_valid[1] !== 1'b0 || out_count[1] !== 8'd2) begin
      errors++;
      $display("FAIL bp_count: got v=%b c=%0d want 0 2",
               out_valid[1], out_count[1]);
    end
  endtask

  task automatic test_isolation();
    lane_sel_t sels [4];
    sels = '{LANE_ZERO, LANE_ONE, LANE_TWO, LANE_ZERO};
    out_ready = 4'b0111;
    drive(1'b1, LANE_THREE, 32'h3333_3333);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, sels[k], 32'hA0 + k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL iso_ready%0d: got %b want 1", k, in_ready);
      end
      cycle();
      checks++;
      if (out_valid[sels[k]] !== 1'b1 ||
          out_data[sels[k]] !== 32'hA0 + k ||
          out_valid[3] !== 1'b1 || out_data[3] !== 32'h3333_3333) begin
        errors++;
        $display("FAIL iso_route%0d: got d=%h d3=%h want %h 33333333",
                 k, out_data[sels[k]], out_data[3], 32'hA0 + k);
      end
    end
    drive(1'b0, LANE_ZERO, '0);
    out_ready = 4'b1111;
    cycle();
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] prev;
    logic saw_wrap;
    start = mcount[0];
    prev = out_count[0];
    saw_wrap = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, LANE_ZERO, 32'h5000_0000 + k);
      cycle();
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== 32'h5000_0000 + k) begin
        errors++;
        $display("FAIL stream%0d: got v=%b d=%h want 1 %h",
                 k, out_valid[0], out_data[0], 32'h5000_0000 + k);
      end
      if (prev == 8'hFF && out_count[0] == 8'h00) saw_wrap = 1'b1;
      prev = out_count[0];
    end
    drive(1'b0, LANE_ZERO, '0);
    cycle();
    checks++;
    if (out_count[0] !== start || !saw_wrap) begin
      errors++;
      $display("FAIL stream_wrap: got c=%0d wrap=%b want %0d 1",
               out_count[0], saw_wrap, start);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b1111;
    drive(1'b1, LANE_ONE, 32'h7777_7777);
    @(negedge clk);
    #1 rst_n = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 4'b0000 || out_count !== '0) begin
      errors++;
      $display("FAIL rmid_reset: got v=%b want 0000", out_valid);
    end
    drive(1'b0, LANE_ZERO, '0);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_dropped: got %b want 0", out_valid[1]);
    end
    drive(1'b1, LANE_ONE, 32'h8888_8888);
    cycle();
    drive(1'b0, LANE_ZERO, '0);
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h8888_8888) begin
      errors++;
      $display("FAIL rmid_next: got v=%b d=%h want 1 88888888",
               out_valid[1], out_data[1]);
    end
    cycle();
    cycle();
    checks++;
    if (out_count[1] !== 8'd1) begin
      errors++;
      $display("FAIL rmid_count: got %0d want 1", out_count[1]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 4'b0000;
    drive(1'b0, LANE_ZERO, '0);
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL drain_lane%0d: got %0d pending want 0",
                 i, q[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
